// File: rtl/mmio_bus_initiator.sv
// Command-stream initiator for the FPro MMIO bus: valid/ready commands in, cs/wr/rd strobes out,
// read data back on a valid/ready response stream. Define MMIO_INIT_BURST_EN to enable read bursts.
module mmio_bus_initiator #(
    parameter int RD_LAT = 0,
    parameter int LEN_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_wr,
    input  logic [20:0]      cmd_addr,
    input  logic [31:0]      cmd_wdata,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_last,
    output logic             busy,
    output logic             mmio_cs,
    output logic             mmio_wr,
    output logic             mmio_rd,
    output logic [20:0]      mmio_addr,
    output logic [31:0]      mmio_wr_data,
    input  logic [31:0]      mmio_rd_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_e;

    // WAIT counts down from RD_LAT-1; the sample happens when it reaches zero.
    localparam logic [1:0] WAIT_INIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    state_e      state_q, state_d;
    logic        op_wr_q, op_wr_d;
    logic [1:0]  wait_cnt_q, wait_cnt_d;
    logic [20:0] addr_q, addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        busy_q, busy_d;
    logic        cs_q, cs_d;
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_last_q, rsp_last_d;

`ifdef MMIO_INIT_BURST_EN
    localparam logic [LEN_W:0] BEAT_ONE = 1;
    logic [LEN_W:0] beats_q, beats_d;
`else
    logic unused_len;
    assign unused_len = ^cmd_len;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        op_wr_d    = op_wr_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        wr_data_d  = wr_data_q;
        rsp_data_d = rsp_data_q;
`ifdef MMIO_INIT_BURST_EN
        beats_d    = beats_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d  = cmd_addr;
                    op_wr_d = cmd_wr;
                    if (cmd_wr) begin
                        wr_data_d = cmd_wdata;
                    end
`ifdef MMIO_INIT_BURST_EN
                    beats_d = {1'b0, cmd_len} + BEAT_ONE;
`endif
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (op_wr_q) begin
                    state_d = S_IDLE;
                end else if (RD_LAT == 0) begin
                    rsp_data_d = mmio_rd_data;
                    state_d    = S_RESP;
                end else begin
                    wait_cnt_d = WAIT_INIT;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 2'd0) begin
                    rsp_data_d = mmio_rd_data;
                    state_d    = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 2'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
`ifdef MMIO_INIT_BURST_EN
                    if (beats_q == BEAT_ONE) begin
                        state_d = S_IDLE;
                    end else begin
                        // Only the register field advances, so a burst wraps inside its slot.
                        addr_d  = {addr_q[20:5], addr_q[4:0] + 5'd1};
                        beats_d = beats_q - BEAT_ONE;
                        state_d = S_ACCESS;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered without a cycle of lag.
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        cs_d        = (state_d == S_ACCESS);
        wr_d        = cs_d && op_wr_d;
        rd_d        = cs_d && !op_wr_d;
        rsp_valid_d = (state_d == S_RESP);
`ifdef MMIO_INIT_BURST_EN
        rsp_last_d  = (state_d == S_RESP) && (beats_d == BEAT_ONE);
`else
        rsp_last_d  = (state_d == S_RESP);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
            state_q     <= S_IDLE;
            op_wr_q     <= 1'b0;
            wait_cnt_q  <= 2'd0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            rsp_data_q  <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            cs_q        <= 1'b0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
`ifdef MMIO_INIT_BURST_EN
            beats_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_wr_q     <= op_wr_d;
            wait_cnt_q  <= wait_cnt_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            rsp_data_q  <= rsp_data_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            cs_q        <= cs_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
`ifdef MMIO_INIT_BURST_EN
            beats_q     <= beats_d;
`endif
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign busy         = busy_q;
    assign mmio_cs      = cs_q;
    assign mmio_wr      = wr_q;
    assign mmio_rd      = rd_q;
    assign mmio_addr    = addr_q;
    assign mmio_wr_data = wr_data_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_last     = rsp_last_q;
    assign rsp_data     = rsp_data_q;

endmodule
